// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit for EX; stalls the pipeline until HI/LO are ready.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        stall_req_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  word_t       opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  word_t       hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  // Operand decode for the accept cycle
  logic  op_signed, op_is_div, a_neg, b_neg, div_by_zero;
  word_t mag_a, mag_b;

  assign op_signed   = ~req_op_i[0];
  assign op_is_div   = req_op_i[1];
  assign a_neg       = op_signed & rs_data_i[31];
  assign b_neg       = op_signed & rt_data_i[31];
  assign mag_a       = a_neg ? (word_t'(0) - rs_data_i) : rs_data_i;
  assign mag_b       = b_neg ? (word_t'(0) - rt_data_i) : rt_data_i;
  assign div_by_zero = op_is_div & (rt_data_i == '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod, fast_res;
  assign fast_prod = {32'b0, mag_a} * {32'b0, mag_b};
  assign fast_res  = (a_neg ^ b_neg) ? (64'd0 - fast_prod) : fast_prod;
`endif

  // One iteration step; multiplier/dividend magnitude lives in acc_q[31:0]
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem;
  logic [33:0] div_diff;
  logic [63:0] div_next, iter_next, prod_fix;
  word_t       quo_fix, rem_fix;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_rem   = acc_q[63:31];
  assign div_diff  = {1'b0, div_rem} - {2'b0, opb_q};
  assign div_next  = div_diff[33] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};
  assign iter_next = is_div_q ? div_next : mul_next;
  assign prod_fix  = neg_res_q ? (64'd0 - iter_next) : iter_next;
  assign quo_fix   = neg_res_q ? (word_t'(0) - iter_next[31:0]) : iter_next[31:0];
  assign rem_fix   = neg_rem_q ? (word_t'(0) - iter_next[63:32]) : iter_next[63:32];

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Flush overrides every transition, including completion
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (div_by_zero) state_d = StDone;
`ifdef MULDIV_FAST_MUL_EN
            else if (!op_is_div) state_d = StDone;
`endif
            else state_d = StBusy;
          end
        end
        StBusy:  if (cnt_q == 6'd31) state_d = StDone;
        StDone:  if (!hold_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stall_req_o = ~flush_i & (((state_q == StIdle) & req_valid_i) | (state_q == StBusy));
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = (state_d == StDone);
    if (!flush_i) begin
      if (state_q == StIdle && req_valid_i) begin
        cnt_d     = '0;
        acc_d     = {32'b0, mag_a};
        opb_d     = mag_b;
        is_div_d  = op_is_div;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        if (div_by_zero) begin
          hi_d = rs_data_i;
          lo_d = 32'hFFFF_FFFF;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!op_is_div) begin
          hi_d = fast_res[63:32];
          lo_d = fast_res[31:0];
        end
`endif
      end else if (state_q == StBusy) begin
        acc_d = iter_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d = is_div_q ? rem_fix : prod_fix[63:32];
          lo_d = is_div_q ? quo_fix : prod_fix[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed ops push expected HI/LO, a monitor checks on done.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs_data, rt_data;
  logic        flush, hold;
  logic        stall_req, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] sb_q[$];
  logic        done_prev = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_op_i   (req_op),
    .rs_data_i  (rs_data),
    .rt_data_i  (rt_data),
    .flush_i    (flush),
    .hold_i     (hold),
    .stall_req_o(stall_req),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on each new completion
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'd0);
      end else begin
        chk("result_hi_lo", {hi, lo}, sb_q.pop_front());
      end
    end
    done_prev = done;
  end

  // Entered just after a negedge; returns just after a negedge with req_valid low.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input int hold_cycles);
    int cyc;
    int n_stall;
    bit seen;
    sb_q.push_back({eh, el});
    req_valid = 1'b1;
    req_op    = op;
    rs_data   = a;
    rt_data   = b;
    cyc = 0;
    n_stall = 0;
    seen = 1'b0;
    while (cyc < 100) begin
      #1;
      if (stall_req) n_stall++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_latency"}, 64'(cyc), 64'(lat));
      chk({name, "_stall_cycles"}, 64'(n_stall), 64'(lat));
      for (int h = 0; h < hold_cycles; h++) begin
        hold = 1'b1;
        @(negedge clk);
        #1;
        chk({name, "_hold_done"}, {63'd0, done}, 64'd1);
        chk({name, "_hold_stable"}, {hi, lo}, {eh, el});
      end
      hold = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({name, "_no_restart"}, {62'd0, done, stall_req}, 64'd0);
  endtask

  initial begin
    int done_cnt;
    int cyc;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    rs_data = '0;
    rt_data = '0;
    flush = 1'b0;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, done, stall_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulLat, 0);
    do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 0);
    do_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat, 0);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DivLat, 0);
    do_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);
    do_op("multu_big", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, MulLat, 0);

    // Prior result hi/lo = 1/2, then a flushed divide must leave it untouched
    do_op("multu_prior", 2'd1, 32'h8000_0001, 32'd2, 32'd1, 32'd2, MulLat, 0);
    req_valid = 1'b1;
    req_op    = 2'd3;
    rs_data   = 32'd1000;
    rt_data   = 32'd3;
    for (cyc = 0; cyc < 10; cyc++) @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("flush_cycle_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done || stall_req) done_cnt++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {32'd1, 32'd2});

    do_op("multu_hold", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, MulLat, 3);
    do_op("multu_b2b", 2'd1, 32'd2, 32'd2, 32'd0, 32'd4, MulLat, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
